// File: rtl/btn_debouncer.sv
// Multi-channel pushbutton debouncer with a level output, press/release pulses
// and a typematic auto-repeat pulse for each channel.
module btn_debouncer #(
  parameter int N_BTN      = 5,
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [25:0] DB_LAST    = 26'(DB_CYCLES - 1);
  localparam logic [25:0] RPT_FIRST  = 26'(RPT_DELAY - 1);
  // Reloading here instead of zero makes later repeats arrive every RPT_PERIOD cycles.
  localparam logic [25:0] RPT_RELOAD = 26'(RPT_DELAY - RPT_PERIOD);

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
      state_t      state_reg;
      logic [25:0] db_cnt_reg;
      logic [25:0] rpt_cnt_reg;
      logic        level_reg;
      logic        press_reg;
      logic        release_reg;
      logic        repeat_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg   <= IDLE;
          db_cnt_reg  <= '0;
          rpt_cnt_reg <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          repeat_reg  <= 1'b0;
        end else begin
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          repeat_reg  <= 1'b0;
          case (state_reg)
            IDLE: begin
              if (sync2_reg[gi]) begin
                state_reg  <= PRESS_WAIT;
                db_cnt_reg <= '0;
              end
            end
            PRESS_WAIT: begin
              if (!sync2_reg[gi]) begin
                state_reg <= IDLE;
              end else if (db_cnt_reg == DB_LAST) begin
                state_reg   <= HELD;
                level_reg   <= 1'b1;
                press_reg   <= 1'b1;
                repeat_reg  <= 1'b1;
                rpt_cnt_reg <= '0;
              end else begin
                db_cnt_reg <= db_cnt_reg + 26'd1;
              end
            end
            HELD: begin
              if (!sync2_reg[gi]) begin
                state_reg  <= RELEASE_WAIT;
                db_cnt_reg <= '0;
              end else if (rpt_cnt_reg == RPT_FIRST) begin
                repeat_reg  <= 1'b1;
                rpt_cnt_reg <= RPT_RELOAD;
              end else begin
                rpt_cnt_reg <= rpt_cnt_reg + 26'd1;
              end
            end
            RELEASE_WAIT: begin
              // A bounce back high resumes the hold with the repeat count untouched.
              if (sync2_reg[gi]) begin
                state_reg <= HELD;
              end else if (db_cnt_reg == DB_LAST) begin
                state_reg   <= IDLE;
                level_reg   <= 1'b0;
                release_reg <= 1'b1;
              end else begin
                db_cnt_reg <= db_cnt_reg + 26'd1;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_repeat[gi]  = repeat_reg;
    end
  endgenerate

endmodule
